sdram_timing_counters: RTL and testbench
========================================

# sdram_timing_counters

Multi-channel, parametrised wait-state / interval timer bank for the i386 SDRAM controller. Each channel is an independent down-counter with a one-shot mode (tRCD, tRP, CAS wait states) and a periodic auto-reload mode (refresh interval). Each channel also carries a small saturating pending-event counter with a request/acknowledge handshake, so the controller FSM can defer servicing an expiry without losing it. It replaces the single-channel, level-loaded wait-state counter: load is a synchronous strobe and reset is a true asynchronous reset.

## Interface
Parameters:
- NCH, 4, number of independent channels
- WIDTH, 16, counter and load-value width in bits
- PEND_MAX, 3, saturation value of the per-channel pending counter (≥1); PW = $clog2(PEND_MAX+1)

Ports:
- CLK  in  1  single clock, all state updates on the rising edge
- RST  in  1  reset, asynchronous and active-high
- LOAD  in  NCH  per-channel synchronous load strobe, active-high
- X  in  NCH*WIDTH  load values; channel i uses X[i*WIDTH +: WIDTH]
- MODE  in  NCH  sampled on LOAD: 0 = one-shot, 1 = periodic
- HOLD  in  NCH  per-channel count freeze, active-high
- ACK  in  NCH  per-channel acknowledge; consumes one pending event
- ZERO  out  NCH  level; channel count register equals 0
- EXPIRE  out  NCH  registered one-cycle pulse per expiry
- REQ  out  NCH  level; channel pending count is non-zero
- PEND  out  NCH*PW  pending count per channel, same packing as X
- OVF  out  NCH  sticky; an expiry occurred while pending count was saturated

## Operation
Per-channel state: cnt[WIDTH], reload[WIDTH], mode_r, pend[PW], expire_r, ovf_r.
- Reset values: cnt=0, reload=0, mode_r=0, pend=0. Outputs: ZERO=all 1, EXPIRE=0, REQ=0, PEND=0, OVF=0.
- Count update, first matching rule wins:
  1. LOAD: cnt<=X_i, reload<=X_i, mode_r<=MODE_i, ovf_r<=0. No expiry this cycle; HOLD ignored.
  2. HOLD: cnt unchanged, no expiry.
  3. cnt==1: expiry. One-shot: cnt<=0. Periodic: cnt<=reload.
  4. cnt>1: cnt<=cnt-1.
  5. cnt==0: unchanged, no expiry. This includes periodic mode with reload==0.
- expire_r<=1 on the edge where rule 3 fires, else 0. EXPIRE = expire_r.
- ZERO = (cnt==0), combinational from the register. In periodic mode with reload>0, ZERO never asserts after the first load.
- Pending counter, evaluated on the same edge using the rule-3 expiry event:
  - expiry & !ack_eff: if pend<PEND_MAX then pend+1, else pend unchanged and ovf_r<=1.
  - ack_eff & !expiry: pend-1.
  - both: pend unchanged, no overflow.
  - ack_eff = ACK_i & (pend!=0). ACK with pend==0 is ignored.
- LOAD does not clear pend. LOAD clears ovf_r; if overflow coincides with LOAD, the clear wins. An expiry cannot coincide with LOAD.
- REQ = (pend!=0). OVF = ovf_r.
- All arithmetic is unsigned, WIDTH bits, with no wrap: the counter never decrements below 0.
- Channels are fully independent; no cross-channel priority.

## Timing
- Load at edge k with X=N≥1, one-shot, HOLD low: ZERO and EXPIRE rise after edge k+N. EXPIRE falls after edge k+N+1. Latency is N cycles.
- Load with X=0: ZERO is high after edge k, with no EXPIRE and no pend change.
- Periodic with reload=N: EXPIRE pulses every N cycles. For N=1, EXPIRE stays high every cycle until reload or HOLD.
- Each HOLD-high cycle delays expiry by exactly one cycle.
- REQ rises the same cycle as EXPIRE. ACK sampled at edge j decrements pend after edge j.
- RST asserted mid-count forces all state to reset values immediately (asynchronous). The first load is accepted on the first edge after RST deasserts.

## Test plan
- Reset: assert RST mid-count with cnt=5 → immediately ZERO=1, EXPIRE=0, REQ=0, PEND=0, OVF=0.
- One-shot: load X=4 on channel 0 → ZERO and EXPIRE high exactly 4 cycles later, EXPIRE for 1 cycle, PEND=1, REQ=1. ACK → PEND=0 next cycle.
- Periodic and HOLD: load X=3, MODE=1 on channel 1 → EXPIRE at cycles 3, 6, 9 and ZERO never high. HOLD for 2 cycles before cycle 6 → that pulse moves to cycle 8.
- Saturation: periodic X=1, PEND_MAX=3, no ACK → PEND=3 after 3 cycles and OVF=1 on the 4th expiry. Expiry plus ACK in the same cycle → PEND stays 3. Reload → OVF=0 with PEND still 3.
- Load priority: assert LOAD X=7 on the cycle cnt==1 → no EXPIRE, cnt=7. Load X=0 → ZERO=1 with no EXPIRE. Load channels 0–3 with 2, 5, 1, 9 simultaneously → four independent expiries at the matching cycles.

Source files
------------

// File: rtl/sdram_timing_counters.sv
// Bank of independent wait-state / interval down-counters for the SDRAM controller.
// Each channel has one-shot or auto-reload expiry plus a saturating pending-event counter.
module sdram_timing_counters #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 16,
  parameter int PEND_MAX = 3,
  localparam int PW      = $clog2(PEND_MAX + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NCH-1:0]       LOAD,
  input  logic [NCH*WIDTH-1:0] X,
  input  logic [NCH-1:0]       MODE,
  input  logic [NCH-1:0]       HOLD,
  input  logic [NCH-1:0]       ACK,
  output logic [NCH-1:0]       ZERO,
  output logic [NCH-1:0]       EXPIRE,
  output logic [NCH-1:0]       REQ,
  output logic [NCH*PW-1:0]    PEND,
  output logic [NCH-1:0]       OVF
);

  localparam logic [PW-1:0]    PEND_SAT = PW'(PEND_MAX);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] x_i;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] reload;
    logic             mode_r;
    logic [PW-1:0]    pend;
    logic [PW-1:0]    pend_nxt;
    logic             expire_r;
    logic             ovf_r;
    logic             ovf_nxt;
    logic             expiry;
    logic             ack_eff;

    assign x_i = X[i*WIDTH +: WIDTH];

    // Terminal count is cnt==1; a count of 0 is idle, even in periodic mode.
    always_comb begin
      cnt_nxt = cnt;
      expiry  = 1'b0;
      if (LOAD[i]) begin
        cnt_nxt = x_i;
      end else if (!HOLD[i]) begin
        if (cnt == CNT_ONE) begin
          expiry  = 1'b1;
          cnt_nxt = mode_r ? reload : '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
    end

    // Simultaneous expiry and acknowledge cancel out; load-clear of ovf wins.
    always_comb begin
      ack_eff  = ACK[i] && (pend != '0);
      pend_nxt = pend;
      ovf_nxt  = ovf_r;
      if (expiry && !ack_eff) begin
        if (pend != PEND_SAT) pend_nxt = pend + PW'(1);
        else                  ovf_nxt  = 1'b1;
      end else if (ack_eff && !expiry) begin
        pend_nxt = pend - PW'(1);
      end
      if (LOAD[i]) ovf_nxt = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt      <= '0;
        reload   <= '0;
        mode_r   <= 1'b0;
        pend     <= '0;
        expire_r <= 1'b0;
        ovf_r    <= 1'b0;
      end else begin
        cnt      <= cnt_nxt;
        pend     <= pend_nxt;
        expire_r <= expiry;
        ovf_r    <= ovf_nxt;
        if (LOAD[i]) begin
          reload <= x_i;
          mode_r <= MODE[i];
        end
      end
    end

    assign ZERO[i]            = (cnt == '0);
    assign EXPIRE[i]          = expire_r;
    assign REQ[i]             = (pend != '0);
    assign PEND[i*PW +: PW]   = pend;
    assign OVF[i]             = ovf_r;
  end

endmodule

// File: tb/tb_sdram_timing_counters.sv
// Scoreboard bench for sdram_timing_counters: directed scenarios plus random traffic
// against an integer reference model of the channel rules.
module tb_sdram_timing_counters;

  localparam int NCH      = 4;
  localparam int WIDTH    = 16;
  localparam int PEND_MAX = 3;
  localparam int PW       = $clog2(PEND_MAX + 1);

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [NCH-1:0]       LOAD = '0;
  logic [NCH*WIDTH-1:0] X = '0;
  logic [NCH-1:0]       MODE = '0;
  logic [NCH-1:0]       HOLD = '0;
  logic [NCH-1:0]       ACK = '0;
  logic [NCH-1:0]       ZERO;
  logic [NCH-1:0]       EXPIRE;
  logic [NCH-1:0]       REQ;
  logic [NCH*PW-1:0]    PEND;
  logic [NCH-1:0]       OVF;

  sdram_timing_counters #(.NCH(NCH), .WIDTH(WIDTH), .PEND_MAX(PEND_MAX)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .X(X), .MODE(MODE), .HOLD(HOLD), .ACK(ACK),
    .ZERO(ZERO), .EXPIRE(EXPIRE), .REQ(REQ), .PEND(PEND), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NCH-1:0]    zero;
    logic [NCH-1:0]    expire;
    logic [NCH-1:0]    req;
    logic [NCH*PW-1:0] pend;
    logic [NCH-1:0]    ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state, plain integers
  int m_cnt[NCH], m_rel[NCH], m_mode[NCH], m_pend[NCH], m_ovf[NCH], m_exp[NCH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_mode[c] = 0; m_pend[c] = 0; m_ovf[c] = 0; m_exp[c] = 0;
    end
  endtask

  function automatic logic [NCH*WIDTH-1:0] xv(input int c, input int v);
    logic [NCH*WIDTH-1:0] r;
    r = '0;
    r[c*WIDTH +: WIDTH] = WIDTH'(v);
    return r;
  endfunction

  function automatic int dut_pend(input int c);
    return int'(PEND[c*PW +: PW]);
  endfunction

  // Drive one cycle at the falling edge, advance the model, push the expected
  // post-edge outputs; return just after the rising edge.
  task automatic step(input logic [NCH-1:0] ld, input logic [NCH*WIDTH-1:0] x,
                      input logic [NCH-1:0] md, input logic [NCH-1:0] hd,
                      input logic [NCH-1:0] ak);
    exp_t e;
    int   xi;
    bit   ack_eff;
    @(negedge CLK);
    LOAD = ld; X = x; MODE = md; HOLD = hd; ACK = ak;
    for (int c = 0; c < NCH; c++) begin
      xi = int'(x[c*WIDTH +: WIDTH]);
      m_exp[c] = 0;
      if (ld[c]) begin
        m_cnt[c] = xi; m_rel[c] = xi; m_mode[c] = int'(md[c]); m_ovf[c] = 0;
      end else if (!hd[c] && m_cnt[c] > 0) begin
        if (m_cnt[c] == 1) begin
          m_exp[c] = 1;
          m_cnt[c] = (m_mode[c] != 0) ? m_rel[c] : 0;
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
      ack_eff = ak[c] && (m_pend[c] > 0);
      if (m_exp[c] != 0 && !ack_eff) begin
        if (m_pend[c] < PEND_MAX) m_pend[c]++;
        else if (!ld[c]) m_ovf[c] = 1;
      end else if (ack_eff && m_exp[c] == 0) begin
        m_pend[c]--;
      end
      e.zero[c]   = (m_cnt[c] == 0);
      e.expire[c] = (m_exp[c] != 0);
      e.req[c]    = (m_pend[c] != 0);
      e.pend[c*PW +: PW] = PW'(m_pend[c]);
      e.ovf[c]    = (m_ovf[c] != 0);
    end
    q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, '0, '0, '0);
  endtask

  // Monitor: compares every cycle that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("zero",   64'(ZERO),   64'(e.zero));
        chk("expire", 64'(EXPIRE), 64'(e.expire));
        chk("req",    64'(REQ),    64'(e.req));
        chk("pend",   64'(PEND),   64'(e.pend));
        chk("ovf",    64'(OVF),    64'(e.ovf));
      end
    end
  end

  initial begin
    int nexp;
    logic [NCH-1:0]       ld, md, hd, ak;
    logic [NCH*WIDTH-1:0] x;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset_zero", 64'(ZERO), 64'hF);
    chk("reset_expire", 64'(EXPIRE), 64'h0);
    RST = 1'b0;

    // Asynchronous reset mid-count (cnt = 5)
    step(4'b0001, xv(0, 10), '0, '0, '0);
    idle(5);
    chk("pre_reset_zero", 64'(ZERO[0]), 64'h0);
    RST = 1'b1;
    #1;
    chk("async_zero", 64'(ZERO), 64'hF);
    chk("async_expire", 64'(EXPIRE), 64'h0);
    chk("async_req", 64'(REQ), 64'h0);
    chk("async_pend", 64'(PEND), 64'h0);
    chk("async_ovf", 64'(OVF), 64'h0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();

    // One-shot, X=4 on channel 0
    step(4'b0001, xv(0, 4), '0, '0, '0);
    idle(3);
    chk("oneshot_early", 64'(EXPIRE[0]), 64'h0);
    idle(1);
    chk("oneshot_expire", 64'(EXPIRE[0]), 64'h1);
    chk("oneshot_zero", 64'(ZERO[0]), 64'h1);
    chk("oneshot_pend", 64'(dut_pend(0)), 64'h1);
    idle(1);
    chk("oneshot_pulse_end", 64'(EXPIRE[0]), 64'h0);
    step('0, '0, '0, '0, 4'b0001);
    chk("oneshot_ack", 64'(dut_pend(0)), 64'h0);

    // Periodic X=3 on channel 1, HOLD 2 cycles before the second pulse
    step(4'b0010, xv(1, 3), 4'b0010, '0, '0);
    nexp = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 4 || k == 5) step('0, '0, '0, 4'b0010, '0);
      else                  idle(1);
      if (EXPIRE[1]) begin
        nexp++;
        chk("periodic_when", 64'(k), (nexp == 1) ? 64'd3 : (nexp == 2) ? 64'd8 : 64'd11);
      end
      if (ZERO[1]) chk("periodic_zero", 64'(ZERO[1]), 64'h0);
    end
    chk("periodic_count", 64'(nexp), 64'd3);
    step(4'b0010, xv(1, 0), '0, '0, 4'b0010);

    // Saturation, periodic X=1 on channel 2
    step(4'b0100, xv(2, 1), 4'b0100, '0, '0);
    idle(3);
    chk("sat_pend", 64'(dut_pend(2)), 64'd3);
    chk("sat_no_ovf", 64'(OVF[2]), 64'h0);
    idle(1);
    chk("sat_ovf", 64'(OVF[2]), 64'h1);
    step('0, '0, '0, '0, 4'b0100);
    chk("sat_ack_expire", 64'(dut_pend(2)), 64'd3);
    step(4'b0100, xv(2, 1), 4'b0100, '0, '0);
    chk("sat_reload_ovf", 64'(OVF[2]), 64'h0);
    chk("sat_reload_pend", 64'(dut_pend(2)), 64'd3);
    step(4'b0100, xv(2, 0), '0, '0, '0);

    // Load priority on channel 3
    step(4'b1000, xv(3, 2), '0, '0, '0);
    idle(1);
    step(4'b1000, xv(3, 7), '0, '0, '0);
    chk("ldprio_expire", 64'(EXPIRE[3]), 64'h0);
    step(4'b1000, xv(3, 0), '0, '0, '0);
    chk("ldzero_zero", 64'(ZERO[3]), 64'h1);
    chk("ldzero_expire", 64'(EXPIRE[3]), 64'h0);

    // Simultaneous loads 2, 5, 1, 9
    step(4'b1111, xv(0, 2) | xv(1, 5) | xv(2, 1) | xv(3, 9), '0, '0, '0);
    idle(10);
    step('0, '0, '0, '0, 4'b1111);
    step('0, '0, '0, '0, 4'b1111);
    step('0, '0, '0, '0, 4'b1111);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      ld = '0; md = '0; hd = '0; ak = '0; x = '0;
      for (int c = 0; c < NCH; c++) begin
        ld[c] = ($urandom_range(0, 9) == 0);
        md[c] = $urandom_range(0, 1) == 1;
        hd[c] = ($urandom_range(0, 7) == 0);
        ak[c] = ($urandom_range(0, 5) == 0);
        x[c*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 12));
      end
      step(ld, x, md, hd, ak);
    end
    idle(2);

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
